// File: rtl/ei_pkg.sv
// Shared constants and FSM encoding for the ei_divider sequential divider.
package ei_pkg;

   localparam int unsigned DEF_DW_A  = 16;
   localparam int unsigned DEF_DW_B  = 8;
   localparam int unsigned DEF_CNT_W = $clog2(DEF_DW_A);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_t;

endpackage

// File: rtl/ei_divider.sv
// Restoring shift-subtract unsigned divider: one quotient bit per enabled cycle,
// start/busy/done handshake, divide-by-zero flagged alongside the held result.
module ei_divider
   import ei_pkg::*;
#(
   parameter int unsigned DW_A = DEF_DW_A,
   parameter int unsigned DW_B = DEF_DW_B
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic            start,
   input  logic [DW_A-1:0] a_in,
   input  logic [DW_B-1:0] b_in,
   output logic [DW_A-1:0] q_out,
   output logic [DW_B-1:0] r_out,
   output logic            busy,
   output logic            done,
   output logic            div_zero
);

   localparam int unsigned CNT_W = $clog2(DW_A);

   div_state_t state_q, state_d;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [DW_A-1:0]  dvd_q, dvd_d;
   logic [DW_B-1:0]  dvs_q, dvs_d;
   logic [DW_B:0]    rem_q, rem_d;
   logic [DW_A-1:0]  q_q, q_d;
   logic [DW_B-1:0]  r_q, r_d;
   logic             dz_q, dz_d;

   logic            accept;
   logic [DW_B:0]   rem_sh;
   logic            rem_ge;
   logic [DW_B:0]   rem_nx;
   logic [DW_A-1:0] dvd_nx;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else if (en) begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = (b_in != '0) ? RUN : DONE;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (cnt_q == '0) begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      busy     = (state_q == RUN);
      done     = (state_q == DONE);
      q_out    = q_q;
      r_out    = r_q;
      div_zero = dz_q;
   end

   // One restoring step; quotient bits refill the dividend register from the LSB end.
   always_comb begin
      rem_sh = {rem_q[DW_B-1:0], dvd_q[DW_A-1]};
      rem_ge = (rem_sh >= {1'b0, dvs_q});
      rem_nx = rem_ge ? (rem_sh - {1'b0, dvs_q}) : rem_sh;
      dvd_nx = {dvd_q[DW_A-2:0], rem_ge};
   end

   always_comb begin
      accept = start && (state_q != RUN);
      cnt_d  = cnt_q;
      dvd_d  = dvd_q;
      dvs_d  = dvs_q;
      rem_d  = rem_q;
      q_d    = q_q;
      r_d    = r_q;
      dz_d   = dz_q;
      if (accept) begin
         dvd_d = a_in;
         dvs_d = b_in;
         rem_d = '0;
         cnt_d = CNT_W'(DW_A - 1);
         if (b_in == '0) begin
            q_d  = '1;
            r_d  = '0;
            dz_d = 1'b1;
         end
      end else if (state_q == RUN) begin
         dvd_d = dvd_nx;
         rem_d = rem_nx;
         if (cnt_q == '0) begin
            q_d  = dvd_nx;
            r_d  = rem_nx[DW_B-1:0];
            dz_d = 1'b0;
         end else begin
            cnt_d = cnt_q - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
         dvd_q <= '0;
         dvs_q <= '0;
         rem_q <= '0;
         q_q   <= '0;
         r_q   <= '0;
         dz_q  <= 1'b0;
      end else if (en) begin
         cnt_q <= cnt_d;
         dvd_q <= dvd_d;
         dvs_q <= dvs_d;
         rem_q <= rem_d;
         q_q   <= q_d;
         r_q   <= r_d;
         dz_q  <= dz_d;
      end
   end

endmodule

// File: tb/tb_ei_divider.sv
// Randomised self-checking bench for ei_divider against a plain a/b, a%b reference.
module tb_ei_divider;

   logic        clk;
   logic        rst;
   logic        en;
   logic        start;
   logic [15:0] a_in;
   logic [7:0]  b_in;
   logic [15:0] q_out;
   logic [7:0]  r_out;
   logic        busy;
   logic        done;
   logic        div_zero;

   int unsigned errs;
   int unsigned checks;
   int unsigned excl_viol;

   ei_divider #(
      .DW_A(16),
      .DW_B(8)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .start   (start),
      .a_in    (a_in),
      .b_in    (b_in),
      .q_out   (q_out),
      .r_out   (r_out),
      .busy    (busy),
      .done    (done),
      .div_zero(div_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (busy && done) excl_viol++;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Issues a start at the current (post-edge) time and returns in the done cycle.
   task automatic run_div(input logic [15:0] a, input logic [7:0] b);
      logic [15:0] eq;
      logic [7:0]  er;
      logic        ez;
      int          lat;
      int          cyc;
      if (b == 8'd0) begin
         eq = 16'hFFFF;
         er = 8'd0;
         ez = 1'b1;
         lat = 1;
      end else begin
         eq = a / {8'd0, b};
         er = 8'(a % {8'd0, b});
         ez = 1'b0;
         lat = 17;
      end
      a_in  = a;
      b_in  = b;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      a_in  = 16'($urandom);
      b_in  = 8'($urandom);
      cyc   = 1;
      if (b != 8'd0) check_eq("busy_after_accept", 32'(busy), 32'd1);
      while (!done && cyc < 100) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check_eq("latency", cyc, lat);
      check_eq("q", 32'(q_out), 32'(eq));
      check_eq("r", 32'(r_out), 32'(er));
      check_eq("div_zero", 32'(div_zero), 32'(ez));
      if (b != 8'd0) check_eq("q*b+r", 32'(q_out) * 32'(b) + 32'(r_out), 32'(a));
   endtask

   initial begin
      int cyc;
      int ndone;
      logic [15:0] ra;
      logic [7:0]  rb;
      errs      = 0;
      checks    = 0;
      excl_viol = 0;
      rst   = 1'b0;
      en    = 1'b1;
      start = 1'b0;
      a_in  = '0;
      b_in  = '0;
      #23;
      check_eq("rst_q", 32'(q_out), 32'd0);
      check_eq("rst_r", 32'(r_out), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      check_eq("rst_dz", 32'(div_zero), 32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Basic division and done-pulse width
      run_div(16'd12, 8'd3);
      @(posedge clk);
      #1;
      check_eq("done_one_cycle", 32'(done), 32'd0);
      check_eq("q_held", 32'(q_out), 32'd4);

      run_div(16'd200, 8'd7);
      run_div(16'd65535, 8'd255);
      run_div(16'd65535, 8'd1);
      run_div(16'd5, 8'd9);
      @(posedge clk);
      #1;

      // Divide by zero, then a normal result clears the flag
      run_div(16'd1000, 8'd0);
      run_div(16'd9, 8'd3);
      @(posedge clk);
      #1;

      // Ignored mid-run start plus a 5-cycle enable stall
      a_in  = 16'd100;
      b_in  = 8'd10;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc   = 1;
      repeat (3) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      a_in  = 16'd1;
      b_in  = 8'd1;
      start = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
      start = 1'b0;
      en    = 1'b0;
      repeat (5) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check_eq("stall_busy", 32'(busy), 32'd1);
      check_eq("stall_done", 32'(done), 32'd0);
      en = 1'b1;
      while (!done && cyc < 100) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check_eq("stall_latency", cyc, 22);
      check_eq("stall_q", 32'(q_out), 32'd10);
      check_eq("stall_r", 32'(r_out), 32'd0);
      // done held while enable is low
      en = 1'b0;
      @(posedge clk);
      #1;
      check_eq("done_held_en0", 32'(done), 32'd1);
      en = 1'b1;
      @(posedge clk);
      #1;

      // Reset mid-run aborts with no done
      a_in  = 16'd50000;
      b_in  = 8'd7;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (8) @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      check_eq("abort_q", 32'(q_out), 32'd0);
      check_eq("abort_r", 32'(r_out), 32'd0);
      check_eq("abort_busy", 32'(busy), 32'd0);
      check_eq("abort_done", 32'(done), 32'd0);
      check_eq("abort_dz", 32'(div_zero), 32'd0);
      #2;
      rst = 1'b1;
      ndone = 0;
      repeat (25) begin
         @(posedge clk);
         #1;
         if (done) ndone++;
      end
      check_eq("abort_no_done", ndone, 0);
      run_div(16'd50000, 8'd7);

      // Random back-to-back divisions, each started in the previous done cycle
      for (int i = 0; i < 200; i++) begin
         ra = 16'($urandom);
         rb = 8'($urandom_range(255, 1));
         run_div(ra, rb);
      end
      @(posedge clk);
      #1;

      check_eq("busy_done_exclusive", excl_viol, 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
